div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU.
- Sits beside the EX stage. EX asserts start, stalls the pipeline until ready, then drives the result onto the HI/LO write path that the EX→MEM pipeline register captures:
  - i_ex_hi = remainder
  - i_ex_lo = quotient
- Produces one quotient bit per cycle. Supports abort on pipeline flush.

---
 rtl/div_unit_pkg.sv | 20 ++
 rtl/div_step.sv | 34 +++
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the radix-2 divider
// Purpose: FSM state encoding, handshake level names and default width for div_unit.
// Ports: none (package).
package div_unit_pkg;

  localparam int DIV_N_REG_DEFAULT = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration (combinational)
// Purpose: shift the next dividend bit into the partial remainder, trial-subtract
//          the divisor and produce the next remainder/quotient pair.
// Ports:
//   i_rem     partial remainder R (N_REG+1 bits)
//   i_quo     quotient/dividend shift register Q (N_REG bits)
//   i_divisor divisor magnitude (N_REG bits)
//   o_rem     next R
//   o_quo     next Q
module div_step #(
  parameter int N_REG = 32
) (
  input  logic [N_REG:0]   i_rem,
  input  logic [N_REG-1:0] i_quo,
  input  logic [N_REG-1:0] i_divisor,
  output logic [N_REG:0]   o_rem,
  output logic [N_REG-1:0] o_quo
);

  logic [N_REG+1:0] w_shift;
  logic [N_REG+1:0] w_diff;
  logic             w_ge;

  // R never exceeds the divisor, so its top bit is always 0; shifting the full
  // register is therefore identical to {R[N_REG-1:0], Q[N_REG-1]} and keeps every
  // bit of R in use.
  assign w_shift = {i_rem, i_quo[N_REG-1]};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  assign w_ge    = ~w_diff[N_REG+1];

  assign o_rem = w_ge ? w_diff[N_REG:0] : w_shift[N_REG:0];
  assign o_quo = {i_quo[N_REG-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Purpose: EX-side divider; one quotient bit per cycle, abortable on flush.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      request division, held until o_ready
//   i_annul      abort current division
//   i_signed_div 1 = DIV (two's complement), 0 = DIVU
//   i_opdata1    dividend
//   i_opdata2    divisor
//   o_result     {remainder, quotient}
//   o_ready      result valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int N_REG = DIV_N_REG_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_annul,
  input  logic               i_signed_div,
  input  logic [N_REG-1:0]   i_opdata1,
  input  logic [N_REG-1:0]   i_opdata2,
  output logic [2*N_REG-1:0] o_result,
  output logic               o_ready
);

  localparam int            CW   = $clog2(N_REG + 1);
  localparam logic [CW-1:0] LAST = CW'(N_REG);

  div_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [N_REG:0]     r_rem, w_rem_nxt;
  logic [N_REG-1:0]   r_quo, w_quo_nxt;
  logic [N_REG-1:0]   r_divisor, w_divisor_nxt;
  logic               r_neg_q, w_neg_q_nxt;
  logic               r_neg_r, w_neg_r_nxt;
  logic [2*N_REG-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  logic [N_REG:0]     w_step_rem;
  logic [N_REG-1:0]   w_step_quo;
  logic [N_REG-1:0]   w_dvd_mag, w_dvs_mag;
  logic [N_REG-1:0]   w_quo_fix, w_rem_fix;

  div_step #(.N_REG(N_REG)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  // Signed operands are reduced to magnitudes at latch time; 0x8000_0000 maps to
  // itself, which is the correct unsigned magnitude.
  assign w_dvd_mag = (i_signed_div && i_opdata1[N_REG-1]) ? -i_opdata1 : i_opdata1;
  assign w_dvs_mag = (i_signed_div && i_opdata2[N_REG-1]) ? -i_opdata2 : i_opdata2;

  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix = r_neg_r ? -r_rem[N_REG-1:0] : r_rem[N_REG-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rem_nxt     = r_rem;
    w_quo_nxt     = r_quo;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = r_result;
    w_ready_nxt   = r_ready;
    case (r_state)
      DIV_FREE: begin
        if (i_start == DIV_START && !i_annul) begin
          w_quo_nxt     = w_dvd_mag;
          w_rem_nxt     = '0;
          w_divisor_nxt = w_dvs_mag;
          w_neg_q_nxt   = i_signed_div & (i_opdata1[N_REG-1] ^ i_opdata2[N_REG-1]);
          w_neg_r_nxt   = i_signed_div & i_opdata1[N_REG-1];
          w_cnt_nxt     = '0;
          w_state_nxt   = (i_opdata2 == '0) ? DIV_BYZERO : DIV_ON;
        end
      end
      DIV_BYZERO: begin
        if (i_annul) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_state_nxt  = DIV_END;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        // Annul wins over both stepping and completion.
        if (i_annul) begin
          w_state_nxt = DIV_FREE;
        end else if (r_cnt < LAST) begin
          w_rem_nxt = w_step_rem;
          w_quo_nxt = w_step_quo;
          w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          w_result_nxt = {w_rem_fix, w_quo_fix};
          w_ready_nxt  = DIV_RESULT_READY;
          w_state_nxt  = DIV_END;
        end
      end
      DIV_END: begin
        if (i_start == DIV_STOP || i_annul) begin
          w_state_nxt  = DIV_FREE;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
          w_result_nxt = '0;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rem     <= w_rem_nxt;
      r_quo     <= w_quo_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign o_result = r_result;
  assign o_ready  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_annul;
  logic        i_signed_div;
  logic [31:0] i_opdata1;
  logic [31:0] i_opdata2;
  logic [63:0] o_result;
  logic        o_ready;

  int n_assert = 0;
  int n_fail   = 0;

  div_unit #(.N_REG(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_annul      (i_annul),
    .i_signed_div (i_signed_div),
    .i_opdata1    (i_opdata1),
    .i_opdata2    (i_opdata2),
    .o_result     (o_result),
    .o_ready      (o_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic. Signed case done in 64 bits so that
  // -2^31 / -1 yields 2^31, whose low word is 0x8000_0000.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  // Edges after the accepting edge until o_ready: 33 when stepping, and for a zero
  // divisor the single BYZERO->END edge (second edge of the operation).
  task automatic run_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          lat;
    int          exp_lat;
    exp     = ref_div(s, a, b);
    exp_lat = (b == 32'd0) ? 1 : 33;
    i_start      = 1'b1;
    i_signed_div = s;
    i_opdata1    = a;
    i_opdata2    = b;
    tick();
    lat = 0;
    while (!o_ready && lat < 40) begin
      i_opdata1 = $urandom;
      i_opdata2 = $urandom;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, o_result, exp);
    tick();
    check({tag, "_held_ready"}, 64'(o_ready), 64'd1);
    check({tag, "_held_result"}, o_result, exp);
    i_start = 1'b0;
    tick();
    check({tag, "_drop_ready"}, 64'(o_ready), 64'd0);
    check({tag, "_drop_result"}, o_result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] exp_end;
    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_annul      = 1'b0;
    i_signed_div = 1'b0;
    i_opdata1    = '0;
    i_opdata2    = '0;
    tick();
    tick();
    check("reset_ready", 64'(o_ready), 64'd0);
    check("reset_result", o_result, 64'd0);
    i_rst_n = 1'b1;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
    check("divu_100_7_ref", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2);
    run_div("div_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE);
    run_div("divu_5_0", 1'b0, 32'd5, 32'd0);
    run_div("div_5_0", 1'b1, 32'hFFFF_FFFB, 32'd0);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("divu_0_9", 1'b0, 32'd0, 32'd9);

    // Annul at step 10, then a new operation on the following edge.
    i_start      = 1'b1;
    i_signed_div = 1'b0;
    i_opdata1    = 32'd1000;
    i_opdata2    = 32'd3;
    tick();
    for (int k = 0; k < 9; k++) tick();
    i_start = 1'b0;
    i_annul = 1'b1;
    tick();
    check("annul_ready", 64'(o_ready), 64'd0);
    check("annul_result", o_result, 64'd0);
    i_annul = 1'b0;
    run_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3);

    // Asynchronous reset in the middle of stepping.
    i_start   = 1'b1;
    i_opdata1 = 32'd12345;
    i_opdata2 = 32'd17;
    tick();
    for (int k = 0; k < 15; k++) tick();
    i_rst_n = 1'b0;
    #1;
    check("rst_on_ready", 64'(o_ready), 64'd0);
    check("rst_on_result", o_result, 64'd0);
    i_start = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);

    // Asynchronous reset while a nonzero result is presented.
    exp_end      = ref_div(1'b0, 32'hDEAD_BEEF, 32'd1234);
    i_start      = 1'b1;
    i_opdata1    = 32'hDEAD_BEEF;
    i_opdata2    = 32'd1234;
    tick();
    for (int k = 0; k < 33; k++) tick();
    check("end_result_pre_rst", o_result, exp_end);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_end_ready", 64'(o_ready), 64'd0);
    check("rst_end_result", o_result, 64'd0);
    i_start = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // Randomized operations against the reference.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_div($sformatf("rand_%0d", n), 1'($urandom_range(0, 1)), ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
